// File: rtl/dmem_mmio_pkg.sv
// dmem_mmio_pkg: shared constants and types for the data-memory / MMIO responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_mmio_pkg;

  // Address nibble DataAdr[31:28] that selects the MMIO window
  localparam logic [3:0] MMIO_BASE = 4'hF;

  // MMIO register offsets, taken from DataAdr[3:2]
  localparam logic [1:0] REG_TXDATA   = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_STORECNT = 2'd2;

  // STATUS register bit positions
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_ACTIVE  = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  // UART serializer states
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } ser_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: turns bytes into UART frames (start, 8 data LSB first, optional parity, stop).
// Latency: a byte accepted on edge N drives the start bit from edge N; uart_tx is registered.
// Backpressure: in_rdy only when idle or on the last stop cycle, so frames run back to back.
// Build option: DMEM_MMIO_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx_serializer
  import dmem_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_vld,
  input  logic [7:0] in_dat,
  output logic       in_rdy,
  output logic       uart_tx,
  output logic       line_active
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  ser_state_e     state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           baud_last;
`ifdef DMEM_MMIO_PARITY_EN
  logic           par_q, par_d;
`endif

  assign baud_last   = (baud_q == BAUD_LAST);
  assign in_rdy      = (state_q == S_IDLE) || ((state_q == S_STOP) && baud_last);
  assign uart_tx     = tx_q;
  assign line_active = (state_q != S_IDLE);

  // Next-state logic: tx_d is the line level for the state being entered, so the pin is a flop
  always_comb begin
    state_d = state_q;
    baud_d  = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
`ifdef DMEM_MMIO_PARITY_EN
    par_d   = par_q;
`endif
    if ((state_q != S_IDLE) && !baud_last) begin
      baud_d = baud_q + BW'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (in_vld) begin
          state_d = S_START;
          shift_d = in_dat;
          tx_d    = 1'b0;
`ifdef DMEM_MMIO_PARITY_EN
          par_d   = ^in_dat;
`endif
        end
      end
      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (baud_last) begin
          if (bit_q == 3'd7) begin
`ifdef DMEM_MMIO_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (baud_last) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          if (in_vld) begin
            state_d = S_START;
            shift_d = in_dat;
            tx_d    = 1'b0;
`ifdef DMEM_MMIO_PARITY_EN
            par_d   = ^in_dat;
`endif
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State register; reset abandons any frame and parks the line high
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef DMEM_MMIO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef DMEM_MMIO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: data RAM plus an MMIO window whose TXDATA stores are queued and sent on a UART line.
// Latency: loads are combinational from DataAdr; stores, pushes and counters update on the clk edge.
// Backpressure: none toward the CPU; a TXDATA push into a full FIFO is dropped and sets sticky overflow.
// Build option: define DMEM_MMIO_PARITY_EN for 8E1 frames instead of 8N1.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int MEM_WORDS    = 64,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   ram_q [MEM_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   storecnt_q, storecnt_d;

  logic          sel_mmio;
  logic [1:0]    reg_off;
  logic [AW-1:0] ram_idx;
  logic          ram_we, push_req, push, pop, full, empty, status_wr;
  logic          ser_rdy, line_active;
  logic [31:0]   status;
  logic          unused_adr;

  assign sel_mmio   = (DataAdr[31:28] == MMIO_BASE);
  assign reg_off    = DataAdr[3:2];
  assign ram_idx    = DataAdr[AW+1:2];
  // Upper RAM bits alias and the byte offset is ignored
  assign unused_adr = ^{DataAdr[27:AW+2], DataAdr[1:0]};

  assign ram_we     = MemWrite && !sel_mmio;
  assign push_req   = MemWrite && sel_mmio && (reg_off == REG_TXDATA);
  assign status_wr  = MemWrite && sel_mmio && (reg_off == REG_STATUS);
  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  // Full check uses the registered count, so a same-cycle pop never rescues a push
  assign push       = push_req && !full;
  assign pop        = ser_rdy && !empty;
  assign tx_busy    = line_active || !empty;

  // FIFO/overflow/store-counter next state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    storecnt_d = storecnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    if (push_req && full) begin
      ovf_d = 1'b1;
    end else if (status_wr) begin
      ovf_d = 1'b0;
    end
    if (ram_we) storecnt_d = storecnt_q + 32'd1;
  end

  // Control registers; reset empties the FIFO and clears counters
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      storecnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      storecnt_q <= storecnt_d;
    end
  end

  // Storage arrays: RAM survives reset, FIFO slots are only meaningful under count
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= WriteData;
    if (push)   fifo_q[wr_ptr_q] <= WriteData[7:0];
  end

  // STATUS word assembled from registered state only
  always_comb begin
    status                     = '0;
    status[ST_FULL]            = full;
    status[ST_EMPTY]           = empty;
    status[ST_ACTIVE]          = line_active;
    status[ST_OVF]             = ovf_q;
    status[ST_CNT_LSB +: 8]    = {{(8-CW){1'b0}}, count_q};
  end

  // Load path: combinational so a single-cycle lw sees data in the same cycle
  always_comb begin
    ReadData = ram_q[ram_idx];
    if (sel_mmio) begin
      case (reg_off)
        REG_STATUS:   ReadData = status;
        REG_STORECNT: ReadData = storecnt_q;
        default:      ReadData = '0;
      endcase
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk        (clk),
    .reset      (reset),
    .in_vld     (!empty),
    .in_dat     (fifo_q[rd_ptr_q]),
    .in_rdy     (ser_rdy),
    .uart_tx    (uart_tx),
    .line_active(line_active)
  );

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed plus randomized checks of RAM, MMIO registers and the UART line.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_dmem_mmio;

  localparam int MEM_WORDS  = 64;
  localparam int FIFO_DEPTH = 8;
  localparam int CPB        = 4;
`ifdef DMEM_MMIO_PARITY_EN
  localparam int BITS_PER_FRAME = 11;
`else
  localparam int BITS_PER_FRAME = 10;
`endif
  localparam int FL = BITS_PER_FRAME * CPB;

  localparam logic [31:0] A_TXDATA   = 32'hF000_0000;
  localparam logic [31:0] A_STATUS   = 32'hF000_0004;
  localparam logic [31:0] A_STORECNT = 32'hF000_0008;
  localparam logic [31:0] A_REG3     = 32'hF000_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        uart_tx;
  logic        tx_busy;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] ram_m [MEM_WORDS];
  bit          written [MEM_WORDS];
  logic [31:0] storecnt_m = '0;

  always #5 clk = ~clk;

  dmem_mmio #(
    .MEM_WORDS(MEM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .MemWrite(MemWrite),
    .DataAdr(DataAdr),
    .WriteData(WriteData),
    .ReadData(ReadData),
    .uart_tx(uart_tx),
    .tx_busy(tx_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // STATUS word built from its field meanings
  function automatic logic [31:0] status_word(input bit full, input bit empty, input bit active,
                                              input bit ovf, input int cnt);
    logic [31:0] w;
    w = '0;
    w[0] = full;
    w[1] = empty;
    w[2] = active;
    w[3] = ovf;
    w[15:8] = 8'(cnt);
    return w;
  endfunction

  // Line level during bit slot j of a frame carrying byte b
  function automatic logic line_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
`ifdef DMEM_MMIO_PARITY_EN
    if (j == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    DataAdr = a;
    #1;
    d = ReadData;
  endtask

  // Checks nb gapless frames of exp_q; the first posedge seen is the edge of the first push
  task automatic check_stream(input int nb);
    @(posedge clk);
    for (int k = 1; k <= FL * nb; k++) begin
      int f;
      int j;
      @(posedge clk);
      @(negedge clk);
      f = (k - 1) / FL;
      j = ((k - 1) % FL) / CPB;
      check($sformatf("line_f%0d_slot%0d_c%0d", f, j, k), {31'b0, uart_tx}, {31'b0, line_bit(exp_q[f], j)});
      check($sformatf("busy_f%0d_c%0d", f, k), {31'b0, tx_busy}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] r;
    logic [31:0] rd;
    int          idx;
    int          nb;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("rst_tx_busy", {31'b0, tx_busy}, 32'd0);
    reset = 1'b0;
    load(A_STATUS, rd);
    check("rst_status", rd, status_word(0, 1, 0, 0, 0));
    load(A_STORECNT, rd);
    check("rst_storecnt", rd, 32'd0);

    // Single 0x55 frame, then the line returns idle one cycle later
    exp_q = {8'h55};
    fork
      store(A_TXDATA, 32'hABCD_0055);
      check_stream(1);
    join
    @(posedge clk);
    @(negedge clk);
    check("frame55_idle_tx", {31'b0, uart_tx}, 32'd1);
    check("frame55_busy_fall", {31'b0, tx_busy}, 32'd0);

    // Directed RAM store and aliased load
    store(32'h0000_0040, 32'h1234_5678);
    ram_m[16] = 32'h1234_5678; written[16] = 1'b1; storecnt_m++;
    load(32'h0000_0040, rd);
    check("ram_0x40", rd, 32'h1234_5678);
    load(32'h0000_0140, rd);
    check("ram_alias_0x140", rd, 32'h1234_5678);
    load(A_STORECNT, rd);
    check("storecnt_one", rd, storecnt_m);

    // MMIO reads of write-only/unused slots, ignored stores, no RAM side effect
    store(32'h0000_000C, 32'hCAFE_F00D);
    ram_m[3] = 32'hCAFE_F00D; written[3] = 1'b1; storecnt_m++;
    store(A_REG3, 32'h1111_2222);
    store(A_STORECNT, 32'h7777_7777);
    load(32'h0000_000C, rd);
    check("ram_not_hit_by_mmio", rd, 32'hCAFE_F00D);
    load(A_REG3, rd);
    check("reg3_read_zero", rd, 32'd0);
    load(A_TXDATA, rd);
    check("txdata_read_zero", rd, 32'd0);
    load(A_STORECNT, rd);
    check("storecnt_ignores_mmio", rd, storecnt_m);
    check("no_tx_after_ignored", {31'b0, tx_busy}, 32'd0);

    // Random RAM traffic against a word-array model with aliasing
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      if (a[31:28] == 4'hF) a[31:28] = 4'h0;
      d = $urandom;
      idx = int'((a >> 2) % MEM_WORDS);
      store(a, d);
      ram_m[idx] = d; written[idx] = 1'b1; storecnt_m++;
      load(a, rd);
      check($sformatf("ram_rand_imm_%0d", i), rd, d);
    end
    for (int i = 0; i < MEM_WORDS; i++) begin
      if (written[i]) begin
        r = $urandom;
        if (r[31:28] == 4'hF) r[31:28] = 4'h7;
        r[7:2] = 6'(i);
        load(r, rd);
        check($sformatf("ram_rand_alias_%0d", i), rd, ram_m[i]);
      end
    end
    load(A_STORECNT, rd);
    check("storecnt_rand", rd, storecnt_m);

    // Ten back-to-back pushes: one popped, eight queued, tenth dropped; then clear overflow
    exp_q = {};
    for (int i = 0; i < 9; i++) exp_q.push_back(8'(i));
    fork
      begin
        for (int i = 0; i < 10; i++) store(A_TXDATA, 32'(i));
        load(A_STATUS, rd);
        check("status_full_ovf", rd, status_word(1, 0, 1, 1, FIFO_DEPTH));
        repeat (5) @(posedge clk);
        #1;
        store(A_STATUS, $urandom);
        load(A_STATUS, rd);
        check("status_ovf_cleared", rd, status_word(1, 0, 1, 0, FIFO_DEPTH));
      end
      check_stream(9);
    join
    @(posedge clk);
    @(negedge clk);
    check("burst_idle_tx", {31'b0, uart_tx}, 32'd1);
    check("burst_busy_fall", {31'b0, tx_busy}, 32'd0);
    load(A_STATUS, rd);
    check("burst_status_empty", rd, status_word(0, 1, 0, 0, 0));

    // Random byte bursts, always sent gapless and in order
    for (int t = 0; t < 2; t++) begin
      nb = $urandom_range(1, FIFO_DEPTH);
      exp_q = {};
      for (int i = 0; i < nb; i++) exp_q.push_back(8'($urandom));
      fork
        begin
          for (int i = 0; i < nb; i++) store(A_TXDATA, {$urandom, exp_q[i]} >> 0 & 32'hFFFF_FF00 | 32'(exp_q[i]));
        end
        check_stream(nb);
      join
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rand_burst%0d_idle", t), {31'b0, uart_tx}, 32'd1);
      check($sformatf("rand_burst%0d_busy", t), {31'b0, tx_busy}, 32'd0);
    end

    // Reset in the middle of a frame of zeros with more bytes queued
    store(A_TXDATA, 32'h0000_0000);
    store(A_TXDATA, 32'h0000_0011);
    store(A_TXDATA, 32'h0000_0022);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("pre_reset_data_low", {31'b0, uart_tx}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_uart_high", {31'b0, uart_tx}, 32'd1);
    check("reset_busy_low", {31'b0, tx_busy}, 32'd0);
    load(A_STATUS, rd);
    check("reset_status", rd, 32'h0000_0002);
    load(A_STORECNT, rd);
    check("reset_storecnt", rd, 32'd0);
    load(32'h0000_0040, rd);
    check("reset_ram_kept", rd, ram_m[16]);
    reset = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("post_reset_idle_tx", {31'b0, uart_tx}, 32'd1);
    check("post_reset_idle_busy", {31'b0, tx_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
